ex_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline's execute stage.
- Selects operand forwarding for the E-stage ALU.
- Generates stall and flush controls for the F/D/E/M pipeline registers on load-use hazards, taken branches and multi-cycle mul/div ops.
- Sits beside the execute stage and drives the enable and clear inputs of the IF/ID, ID/EX and EX/MEM registers.

---
 rtl/ex_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall, branch flush, mul/div sequencing.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module ex_hazard_ctrl #(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned PERF_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rs1_D,
   input  logic [4:0]        rs2_D,
   input  logic [4:0]        rs1_E,
   input  logic [4:0]        rs2_E,
   input  logic [4:0]        rd_E,
   input  logic              MemtoReg_E,
   input  logic              MulDiv_E,
   input  logic              PCSrc_E,
   input  logic [4:0]        rd_M,
   input  logic              RegWrite_M,
   input  logic [4:0]        rd_W,
   input  logic              RegWrite_W,
   output logic [1:0]        ForwardA_E,
   output logic [1:0]        ForwardB_E,
   output logic              Stall_F,
   output logic              Stall_D,
   output logic              Stall_E,
   output logic              Flush_D,
   output logic              Flush_E,
   output logic              Flush_M,
   output logic              md_busy,
   output logic [PERF_W-1:0] perf_lw_cnt,
   output logic [PERF_W-1:0] perf_md_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_lw_haz;
   logic             w_lw_stall;
   logic             w_md_stall;
   logic             w_br_flush;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   // M-stage result takes priority over W; x0 is never forwarded
   always_comb begin
      w_fwd_a = 2'b00;
      w_fwd_b = 2'b00;
      if (RegWrite_M && (rd_M != 5'd0) && (rd_M == rs1_E))
         w_fwd_a = 2'b10;
      else if (RegWrite_W && (rd_W != 5'd0) && (rd_W == rs1_E))
         w_fwd_a = 2'b01;
      if (RegWrite_M && (rd_M != 5'd0) && (rd_M == rs2_E))
         w_fwd_b = 2'b10;
      else if (RegWrite_W && (rd_W != 5'd0) && (rd_W == rs2_E))
         w_fwd_b = 2'b01;
   end

   assign w_lw_haz = MemtoReg_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

   // Sequencer next state; branch beats mul/div beats load-use, and BUSY ignores all three
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lw_stall  = 1'b0;
      w_md_stall  = 1'b0;
      w_br_flush  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (PCSrc_E) begin
               w_br_flush = 1'b1;
            end else if (MulDiv_E) begin
               w_md_stall  = 1'b1;
               w_cnt_nxt   = CNT_W'(MD_LATENCY - 2);
               w_state_nxt = S_BUSY;
            end else if (w_lw_haz) begin
               w_lw_stall = 1'b1;
            end
         end
         S_BUSY: begin
            if (r_cnt != '0) begin
               w_md_stall = 1'b1;
               w_cnt_nxt  = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Controls are zero-latency; gating with rst_n drops them the moment reset asserts
   assign ForwardA_E = rst_n ? w_fwd_a : 2'b00;
   assign ForwardB_E = rst_n ? w_fwd_b : 2'b00;
   assign Stall_F    = rst_n & (w_md_stall | w_lw_stall);
   assign Stall_D    = rst_n & (w_md_stall | w_lw_stall);
   assign Stall_E    = rst_n & w_md_stall;
   assign Flush_D    = rst_n & w_br_flush;
   assign Flush_E    = rst_n & (w_br_flush | w_lw_stall);
   assign Flush_M    = rst_n & w_md_stall;
   assign md_busy    = rst_n & (r_state == S_BUSY);

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] r_perf_lw;
   logic [PERF_W-1:0] r_perf_md;
   logic [PERF_W-1:0] r_perf_fl;

   // Saturating event counters, one increment per qualifying cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_lw <= '0;
         r_perf_md <= '0;
         r_perf_fl <= '0;
      end else begin
         if (w_lw_stall && (r_perf_lw != '1))
            r_perf_lw <= r_perf_lw + PERF_W'(1);
         if (w_md_stall && (r_perf_md != '1))
            r_perf_md <= r_perf_md + PERF_W'(1);
         if (w_br_flush && (r_perf_fl != '1))
            r_perf_fl <= r_perf_fl + PERF_W'(1);
      end
   end

   assign perf_lw_cnt    = r_perf_lw;
   assign perf_md_cnt    = r_perf_md;
   assign perf_flush_cnt = r_perf_fl;
`else
   assign perf_lw_cnt    = '0;
   assign perf_md_cnt    = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-occupancy reference model.
module tb_ex_hazard_ctrl;

   localparam int unsigned MD_LAT = 4;
   localparam int unsigned PERF_W = 32;
   localparam longint unsigned PMAX = (64'd1 << PERF_W) - 64'd1;

   logic              clk;
   logic              rst_n;
   logic [4:0]        rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic              MemtoReg_E, MulDiv_E, PCSrc_E, RegWrite_M, RegWrite_W;
   logic [1:0]        ForwardA_E, ForwardB_E;
   logic              Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, md_busy;
   logic [PERF_W-1:0] perf_lw_cnt, perf_md_cnt, perf_flush_cnt;
   logic [6:0]        ctrl;

   int                n_checks;
   int                n_fail;

   // reference model state: cycles the current mul/div has spent in E (0 = none)
   int                occ;
   longint unsigned   m_lw, m_md, m_fl;
   logic [1:0]        e_fa, e_fb;
   logic [6:0]        e_ctrl;

   ex_hazard_ctrl #(.MD_LATENCY(MD_LAT), .PERF_W(PERF_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .MemtoReg_E(MemtoReg_E), .MulDiv_E(MulDiv_E), .PCSrc_E(PCSrc_E),
      .rd_M(rd_M), .RegWrite_M(RegWrite_M), .rd_W(rd_W), .RegWrite_W(RegWrite_W),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
      .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .md_busy(md_busy),
      .perf_lw_cnt(perf_lw_cnt), .perf_md_cnt(perf_md_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

`ifdef HAZARD_PERF_EN
   logic [1:0] s_fa, s_fb, s_lw, s_md, s_fl;
   logic       s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_busy;

   ex_hazard_ctrl #(.MD_LATENCY(MD_LAT), .PERF_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .MemtoReg_E(MemtoReg_E), .MulDiv_E(MulDiv_E), .PCSrc_E(PCSrc_E),
      .rd_M(rd_M), .RegWrite_M(RegWrite_M), .rd_W(rd_W), .RegWrite_W(RegWrite_W),
      .ForwardA_E(s_fa), .ForwardB_E(s_fb),
      .Stall_F(s_sf), .Stall_D(s_sd), .Stall_E(s_se),
      .Flush_D(s_fd), .Flush_E(s_fe), .Flush_M(s_fm), .md_busy(s_busy),
      .perf_lw_cnt(s_lw), .perf_md_cnt(s_md), .perf_flush_cnt(s_fl)
   );
`endif

   assign ctrl = {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, md_busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWrite_M && rd_M != 5'd0 && rd_M == rs) return 2'b10;
      if (RegWrite_W && rd_W != 5'd0 && rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   // One cycle of the reference model: expected outputs for current inputs, then advance
   function automatic void model_cycle();
      int   k;
      logic lw, br, st, bsy;
      k = 0;
      if (occ > 0) k = occ + 1;
      else if (MulDiv_E && !PCSrc_E) k = 1;
      br  = (occ == 0) && PCSrc_E;
      lw  = (occ == 0) && !PCSrc_E && !MulDiv_E && MemtoReg_E && rd_E != 5'd0 &&
            (rd_E == rs1_D || rd_E == rs2_D);
      st  = (k >= 1) && (k < int'(MD_LAT));
      bsy = (k >= 2);
      e_fa   = fwd_sel(rs1_E);
      e_fb   = fwd_sel(rs2_E);
      e_ctrl = {st | lw, st | lw, st, br, br | lw, st, bsy};
      occ    = (k == int'(MD_LAT)) ? 0 : k;
      if (lw && m_lw < PMAX) m_lw++;
      if (st && m_md < PMAX) m_md++;
      if (br && m_fl < PMAX) m_fl++;
   endfunction

   task automatic clear_inputs();
      rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
      MemtoReg_E = 1'b0; MulDiv_E = 1'b0; PCSrc_E = 1'b0;
      RegWrite_M = 1'b0; RegWrite_W = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      occ = 0; m_lw = 0; m_md = 0; m_fl = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input logic [4:0] dm, input logic wm, input logic [4:0] dw,
                          input logic ww, input logic [4:0] s1, input logic [4:0] s2);
      rd_M = dm; RegWrite_M = wm; rd_W = dw; RegWrite_W = ww; rs1_E = s1; rs2_E = s2;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_fwd(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
      MulDiv_E = 1'b1; PCSrc_E = 1'b1; MemtoReg_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
      #1;
      n_checks++;
      if ({ForwardA_E, ForwardB_E} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_fwd: got %b expected 0000", {ForwardA_E, ForwardB_E});
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (ctrl !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", ctrl);
      end
      n_checks++;
      if ({perf_lw_cnt, perf_md_cnt, perf_flush_cnt} !== '0) begin
         n_fail++; $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0",
                            perf_lw_cnt, perf_md_cnt, perf_flush_cnt);
      end
      clear_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_forwarding();
      logic [4:0] dm[5] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd8};
      logic       wm[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [4:0] dw[5] = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd8};
      logic       ww[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0] s1[5] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd8};
      logic [4:0] s2[5] = '{5'd5, 5'd6, 5'd0, 5'd9, 5'd8};
      logic [3:0] ex[5] = '{4'b1010, 4'b0100, 4'b0000, 4'b1001, 4'b0000};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         set_fwd(dm[i], wm[i], dw[i], ww[i], s1[i], s2[i]);
         @(negedge clk);
         n_checks++;
         if ({ForwardA_E, ForwardB_E} !== ex[i]) begin
            n_fail++; $display("FAIL fwd_case%0d: got %b expected %b", i,
                               {ForwardA_E, ForwardB_E}, ex[i]);
         end
      end
   endtask

   task automatic test_load_use();
      logic       mr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [4:0] re[4] = '{5'd7, 5'd0, 5'd0, 5'd4};
      logic [4:0] r1[4] = '{5'd2, 5'd7, 5'd0, 5'd4};
      logic [4:0] r2[4] = '{5'd7, 5'd3, 5'd0, 5'd1};
      logic [6:0] ex[4] = '{7'b1100100, 7'b0, 7'b0, 7'b1100100};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         MemtoReg_E = mr[i]; rd_E = re[i]; rs1_D = r1[i]; rs2_D = r2[i];
         @(negedge clk);
         n_checks++;
         if (ctrl !== ex[i]) begin
            n_fail++; $display("FAIL load_use_cyc%0d: got %b expected %b", i, ctrl, ex[i]);
         end
      end
   endtask

   task automatic test_branch_priority();
      do_reset();
      next_cycle();
      PCSrc_E = 1'b1; MulDiv_E = 1'b1; MemtoReg_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
      @(negedge clk);
      n_checks++;
      if (ctrl !== 7'b0001100) begin
         n_fail++; $display("FAIL branch_prio: got %b expected 0001100", ctrl);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      n_checks++;
      if (ctrl !== 7'b0) begin
         n_fail++; $display("FAIL branch_no_busy: got %b expected 0000000", ctrl);
      end
   endtask

   task automatic test_muldiv_back_to_back();
      int         k;
      logic [6:0] ex;
      do_reset();
      for (int i = 0; i < 2 * int'(MD_LAT) + 1; i++) begin
         next_cycle();
         MulDiv_E = (i < 2 * int'(MD_LAT));
         set_fwd(5'd6, 1'b1, 5'd2, 1'b1, 5'd6, 5'd2);
         @(negedge clk);
         k  = (i < 2 * int'(MD_LAT)) ? (i % int'(MD_LAT)) + 1 : 0;
         ex = {3{k >= 1 && k < int'(MD_LAT)}} << 4;
         ex = ex | {5'b0, k >= 1 && k < int'(MD_LAT), k >= 2};
         n_checks++;
         if (ctrl !== ex) begin
            n_fail++; $display("FAIL muldiv_cyc%0d: got %b expected %b", i, ctrl, ex);
         end
         n_checks++;
         if ({ForwardA_E, ForwardB_E} !== 4'b1001) begin
            n_fail++; $display("FAIL muldiv_fwd_cyc%0d: got %b expected 1001", i,
                               {ForwardA_E, ForwardB_E});
         end
      end
   endtask

   task automatic test_reset_during_busy();
      do_reset();
      next_cycle();
      MulDiv_E = 1'b1;
      set_fwd(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 5'd0);
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (ctrl !== 7'b1110011) begin
         n_fail++; $display("FAIL rst_busy_pre: got %b expected 1110011", ctrl);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ForwardA_E, ForwardB_E, ctrl} !== 11'b0) begin
         n_fail++; $display("FAIL rst_busy_async: got %b expected 0", {ForwardA_E, ForwardB_E, ctrl});
      end
      MulDiv_E = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         @(negedge clk);
         n_checks++;
         if (ctrl !== 7'b0) begin
            n_fail++; $display("FAIL rst_busy_idle%0d: got %b expected 0000000", i, ctrl);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         next_cycle();
         rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
         rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
         rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
         rd_W  = 5'($urandom_range(0, 3));
         MemtoReg_E = ($urandom_range(0, 2) == 0);
         MulDiv_E   = ($urandom_range(0, 7) == 0);
         PCSrc_E    = ($urandom_range(0, 7) == 0);
         RegWrite_M = ($urandom_range(0, 1) == 0);
         RegWrite_W = ($urandom_range(0, 1) == 0);
         @(negedge clk);
         model_cycle();
         n_checks++;
         if ({ForwardA_E, ForwardB_E} !== {e_fa, e_fb}) begin
            n_fail++; $display("FAIL rand_fwd_cyc%0d: got %b expected %b", i,
                               {ForwardA_E, ForwardB_E}, {e_fa, e_fb});
         end
         n_checks++;
         if (ctrl !== e_ctrl) begin
            n_fail++; $display("FAIL rand_ctrl_cyc%0d: got %b expected %b", i, ctrl, e_ctrl);
         end
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
`ifdef HAZARD_PERF_EN
      n_checks++;
      if ({64'(perf_lw_cnt), 64'(perf_md_cnt), 64'(perf_flush_cnt)} !== {m_lw, m_md, m_fl}) begin
         n_fail++; $display("FAIL rand_perf: got %0d/%0d/%0d expected %0d/%0d/%0d",
                            perf_lw_cnt, perf_md_cnt, perf_flush_cnt, m_lw, m_md, m_fl);
      end
`else
      n_checks++;
      if ({perf_lw_cnt, perf_md_cnt, perf_flush_cnt} !== '0) begin
         n_fail++; $display("FAIL rand_perf_tied: got %0d/%0d/%0d expected 0/0/0",
                            perf_lw_cnt, perf_md_cnt, perf_flush_cnt);
      end
`endif
   endtask

   task automatic set_op(input int op);
      clear_inputs();
      case (op)
         1:       begin MemtoReg_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7; end
         2:       MulDiv_E = 1'b1;
         3:       PCSrc_E = 1'b1;
         default: ;
      endcase
   endtask

   task automatic test_perf();
      int ops[11] = '{1, 0, 1, 0, 2, 2, 2, 2, 0, 3, 0};
      longint unsigned e_lw, e_md, e_fl;
      do_reset();
      foreach (ops[i]) begin
         next_cycle();
         set_op(ops[i]);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
`ifdef HAZARD_PERF_EN
      e_lw = 2; e_md = MD_LAT - 1; e_fl = 1;
`else
      e_lw = 0; e_md = 0; e_fl = 0;
`endif
      n_checks++;
      if ({64'(perf_lw_cnt), 64'(perf_md_cnt), 64'(perf_flush_cnt)} !== {e_lw, e_md, e_fl}) begin
         n_fail++; $display("FAIL perf_events: got %0d/%0d/%0d expected %0d/%0d/%0d",
                            perf_lw_cnt, perf_md_cnt, perf_flush_cnt, e_lw, e_md, e_fl);
      end
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         set_op((i % 2 == 0) ? 1 : 0);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
`ifdef HAZARD_PERF_EN
      n_checks++;
      if (perf_lw_cnt !== PERF_W'(7)) begin
         n_fail++; $display("FAIL perf_lw_total: got %0d expected 7", perf_lw_cnt);
      end
      n_checks++;
      if (s_lw !== 2'd3) begin
         n_fail++; $display("FAIL perf_lw_saturate: got %0d expected 3", s_lw);
      end
`else
      n_checks++;
      if (perf_lw_cnt !== '0) begin
         n_fail++; $display("FAIL perf_lw_tied: got %0d expected 0", perf_lw_cnt);
      end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      clear_inputs();
      occ = 0; m_lw = 0; m_md = 0; m_fl = 0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_priority();
      test_muldiv_back_to_back();
      test_reset_during_busy();
      test_random();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
